serial_frame_rx: RTL and testbench

Serial frame receiver that consumes the one-bit-per-clock stream from the `d_ff` input register stage. It detects a start bit, shifts in DATA_W data bits LSB-first and checks an optional even-parity bit and the stop bit. It then presents the received word with a one-cycle valid pulse, or raises an error pulse instead. A wrapping frame counter is provided for bench and debug visibility.

---
 rtl/serial_frame_rx.sv | 100 ++++++++++
 tb/tb_serial_frame_rx.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB-first, optional even parity, stop bit.
// Emits one-cycle valid / parity_err / frame_err pulses and counts good frames.
module serial_frame_rx #(
  parameter int DATA_W    = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy,
  output logic [7:0]        frame_cnt
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, RECOVER} state_t;

  state_t            state;
  logic [IW-1:0]     bit_idx;
  logic [DATA_W-1:0] shreg;
  logic              par_bit;
  logic              par_ok;

  // Even parity over data plus parity bit; always passes when no parity bit is sent.
  assign par_ok = !PARITY_EN || ((^shreg ^ par_bit) == 1'b0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
      frame_cnt  <= 8'd0;
    end else begin
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (!d) begin
            state   <= DATA;
            bit_idx <= '0;
            busy    <= 1'b1;
          end
        end
        DATA: begin
          shreg[bit_idx] <= d;
          bit_idx        <= bit_idx + 1'b1;
          if (bit_idx == LAST_IDX) begin
            bit_idx <= '0;
            state   <= PARITY_EN ? PARITY : STOP;
          end
        end
        PARITY: begin
          par_bit <= d;
          state   <= STOP;
        end
        STOP: begin
          if (d) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (par_ok) begin
              data_out  <= shreg;
              valid     <= 1'b1;
              frame_cnt <= frame_cnt + 8'd1;
            end else begin
              parity_err <= 1'b1;
            end
          end else begin
            // A broken stop bit means we may be mid-character; wait for the line to go idle.
            frame_err  <= 1'b1;
            parity_err <= !par_ok;
            state      <= RECOVER;
          end
        end
        RECOVER: begin
          if (d) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: directed scenarios plus randomized frames
// checked against a frame-level model (expected word, counter, pulses).
module tb_serial_frame_rx;

  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic          d;
  logic [DW-1:0] data_out;
  logic          valid;
  logic          parity_err;
  logic          frame_err;
  logic          busy;
  logic [7:0]    frame_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] exp_data;
  logic [7:0] exp_cnt;

  serial_frame_rx #(.DATA_W(DW), .PARITY_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .d         (d),
    .data_out  (data_out),
    .valid     (valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drives one full frame, one bit per negedge; returns before the stop-bit edge.
  task automatic send_frame(input logic [7:0] dat, input logic par, input logic stop);
    @(negedge clk) d = 1'b0;
    for (int i = 0; i < DW; i++) begin
      @(negedge clk) d = dat[i];
    end
    @(negedge clk) d = par;
    @(negedge clk) d = stop;
  endtask

  task automatic test_reset();
    logic [7:0] dat;
    rst = 1'b1;
    d   = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_data = 8'd0;
    exp_cnt  = 8'd0;
    checks++;
    if ({data_out, valid, parity_err, frame_err, busy, frame_cnt} !== 20'h0) begin
      failures++;
      $display("[TB] FAIL reset_initial: got %h required 0",
               {data_out, valid, parity_err, frame_err, busy, frame_cnt});
    end
    dat = 8'($urandom_range(1, 255));
    send_frame(dat, ^dat, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (valid !== 1'b1 || data_out !== dat || frame_cnt !== 8'd1) begin
      failures++;
      $display("[TB] FAIL reset_preframe: got v=%b data=%h cnt=%0d required v=1 data=%h cnt=1",
               valid, data_out, frame_cnt, dat);
    end
    @(negedge clk) d = 1'b0;
    @(negedge clk) d = 1'b1;
    @(negedge clk) d = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_busy_before: got %b required 1", busy);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({data_out, valid, parity_err, frame_err, busy, frame_cnt} !== 20'h0) begin
      failures++;
      $display("[TB] FAIL reset_async: got %h required 0",
               {data_out, valid, parity_err, frame_err, busy, frame_cnt});
    end
    @(negedge clk);
    rst = 1'b0;
    d   = 1'b1;
    exp_data = 8'd0;
    exp_cnt  = 8'd0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, valid, parity_err, frame_err} !== 4'b0000) begin
        failures++;
        $display("[TB] FAIL reset_idle_%0d: got busy/v/pe/fe=%b required 0000",
                 i, {busy, valid, parity_err, frame_err});
      end
    end
  endtask

  task automatic test_good_frame();
    send_frame(8'hA5, 1'b0, 1'b1);
    @(posedge clk); #1;
    exp_data = 8'hA5;
    exp_cnt  = exp_cnt + 8'd1;
    checks++;
    if ({valid, parity_err, frame_err, busy} !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL good_flags: got v/pe/fe/busy=%b required 1000",
               {valid, parity_err, frame_err, busy});
    end
    checks++;
    if (data_out !== exp_data || frame_cnt !== exp_cnt) begin
      failures++;
      $display("[TB] FAIL good_data: got data=%h cnt=%0d required data=%h cnt=%0d",
               data_out, frame_cnt, exp_data, exp_cnt);
    end
    @(posedge clk); #1;
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL good_pulse_width: got valid=%b required 0", valid);
    end
  endtask

  task automatic test_parity_error();
    send_frame(8'hA5, 1'b1, 1'b1);
    @(posedge clk); #1;
    checks++;
    if ({valid, parity_err, frame_err, busy} !== 4'b0100) begin
      failures++;
      $display("[TB] FAIL parity_flags: got v/pe/fe/busy=%b required 0100",
               {valid, parity_err, frame_err, busy});
    end
    checks++;
    if (data_out !== exp_data || frame_cnt !== exp_cnt) begin
      failures++;
      $display("[TB] FAIL parity_hold: got data=%h cnt=%0d required data=%h cnt=%0d",
               data_out, frame_cnt, exp_data, exp_cnt);
    end
    @(posedge clk); #1;
    checks++;
    if (parity_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL parity_pulse_width: got pe=%b required 0", parity_err);
    end
  endtask

  task automatic test_framing_error();
    send_frame(8'h3C, 1'b0, 1'b0);
    @(posedge clk); #1;
    checks++;
    if ({valid, parity_err, frame_err, busy} !== 4'b0011) begin
      failures++;
      $display("[TB] FAIL frame_flags: got v/pe/fe/busy=%b required 0011",
               {valid, parity_err, frame_err, busy});
    end
    checks++;
    if (data_out !== exp_data || frame_cnt !== exp_cnt) begin
      failures++;
      $display("[TB] FAIL frame_hold: got data=%h cnt=%0d required data=%h cnt=%0d",
               data_out, frame_cnt, exp_data, exp_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) d = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({busy, frame_err, valid} !== 3'b100) begin
        failures++;
        $display("[TB] FAIL recover_hold_%0d: got busy/fe/v=%b required 100",
                 i, {busy, frame_err, valid});
      end
    end
    @(negedge clk) d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL recover_exit_%0d: got busy=%b required 0", i, busy);
      end
    end
    send_frame(8'h81, 1'b0, 1'b1);
    @(posedge clk); #1;
    exp_data = 8'h81;
    exp_cnt  = exp_cnt + 8'd1;
    checks++;
    if (valid !== 1'b1 || data_out !== exp_data || frame_cnt !== exp_cnt) begin
      failures++;
      $display("[TB] FAIL recover_next: got v=%b data=%h cnt=%0d required v=1 data=%h cnt=%0d",
               valid, data_out, frame_cnt, exp_data, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int t1;
    int t2;
    send_frame(8'h3C, 1'b0, 1'b1);
    @(posedge clk); #1;
    t1 = cyc;
    exp_cnt = exp_cnt + 8'd1;
    checks++;
    if (valid !== 1'b1 || data_out !== 8'h3C || frame_cnt !== exp_cnt) begin
      failures++;
      $display("[TB] FAIL b2b_first: got v=%b data=%h cnt=%0d required v=1 data=3c cnt=%0d",
               valid, data_out, frame_cnt, exp_cnt);
    end
    send_frame(8'h81, 1'b0, 1'b1);
    @(posedge clk); #1;
    t2 = cyc;
    exp_cnt  = exp_cnt + 8'd1;
    exp_data = 8'h81;
    checks++;
    if (valid !== 1'b1 || data_out !== exp_data || frame_cnt !== exp_cnt) begin
      failures++;
      $display("[TB] FAIL b2b_second: got v=%b data=%h cnt=%0d required v=1 data=81 cnt=%0d",
               valid, data_out, frame_cnt, exp_cnt);
    end
    checks++;
    if (t2 - t1 !== 11) begin
      failures++;
      $display("[TB] FAIL b2b_spacing: got %0d clocks required 11", t2 - t1);
    end
  endtask

  task automatic test_random_frames();
    logic [7:0] dat;
    logic       par;
    logic       stop;
    logic       par_good;
    logic       good;
    int         kind;
    for (int n = 0; n < 24; n++) begin
      dat      = 8'($urandom_range(0, 255));
      kind     = $urandom_range(0, 3);
      par      = (^dat) ^ (kind == 0);
      stop     = (kind != 1);
      par_good = ((^dat) ^ par) == 1'b0;
      good     = stop && par_good;
      send_frame(dat, par, stop);
      @(posedge clk); #1;
      if (good) begin
        exp_data = dat;
        exp_cnt  = exp_cnt + 8'd1;
      end
      checks++;
      if ({valid, parity_err, frame_err, busy, data_out, frame_cnt} !==
          {good, !par_good, !stop, !stop, exp_data, exp_cnt}) begin
        failures++;
        $display("[TB] FAIL random_%0d: got v/pe/fe/busy=%b data=%h cnt=%0d required %b data=%h cnt=%0d",
                 n, {valid, parity_err, frame_err, busy}, data_out, frame_cnt,
                 {good, !par_good, !stop, !stop}, exp_data, exp_cnt);
      end
      if (!stop) begin
        @(negedge clk) d = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("[TB] FAIL random_recover_%0d: got busy=%b required 0", n, busy);
        end
      end
      repeat ($urandom_range(0, 2)) @(negedge clk) d = 1'b1;
    end
  endtask

  task automatic test_reset_midframe_wrap();
    logic [7:0] dat;
    @(negedge clk) d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) d = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({data_out, valid, parity_err, frame_err, busy, frame_cnt} !== 20'h0) begin
      failures++;
      $display("[TB] FAIL midframe_reset: got %h required 0",
               {data_out, valid, parity_err, frame_err, busy, frame_cnt});
    end
    @(negedge clk);
    rst = 1'b0;
    d   = 1'b1;
    exp_data = 8'd0;
    exp_cnt  = 8'd0;
    @(negedge clk);
    for (int n = 0; n < 256; n++) begin
      dat = 8'($urandom_range(0, 255));
      send_frame(dat, ^dat, 1'b1);
      @(posedge clk); #1;
      exp_data = dat;
      exp_cnt  = exp_cnt + 8'd1;
      checks++;
      if (valid !== 1'b1 || data_out !== exp_data || frame_cnt !== exp_cnt) begin
        failures++;
        $display("[TB] FAIL wrap_frame_%0d: got v=%b data=%h cnt=%0d required v=1 data=%h cnt=%0d",
                 n, valid, data_out, frame_cnt, exp_data, exp_cnt);
      end
    end
    checks++;
    if (frame_cnt !== 8'd0 || valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL wrap_final: got cnt=%0d v=%b required cnt=0 v=1", frame_cnt, valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    d   = 1'b1;
    exp_data = 8'd0;
    exp_cnt  = 8'd0;
    test_reset();
    test_good_frame();
    test_parity_error();
    test_framing_error();
    test_back_to_back();
    test_random_frames();
    test_reset_midframe_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
